// File: rtl/pipe_e_reg.sv
// Execute-stage pipeline register with bubble injection, stall hold, and a stall watchdog.
// Latency: d_* appear on E_* one cycle after a clean edge; all outputs are registered.
// Backpressure: E_stall holds the stage (stall wins over E_bubble); E_bubble loads a nop.
// Optional: define PIPE_E_PERF_CNT_EN to add the perf_stall/bubble/instr counters.
module pipe_e_reg #(
    parameter int DATA_W    = 64,
    parameter int MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              E_stall,
    input  logic              E_bubble,
    input  logic [0:3]        d_stat,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [DATA_W-1:0] d_valC,
    input  logic [DATA_W-1:0] d_valA,
    input  logic [DATA_W-1:0] d_valB,
    input  logic [3:0]        d_dstE,
    input  logic [3:0]        d_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [0:3]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic              E_is_bubble,
    output logic              ctrl_err,
    output logic              stall_timeout,
    output logic [7:0]        stall_run
`ifdef PIPE_E_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_instr_cnt
`endif
);

    typedef struct packed {
        logic [0:3]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] valC;
        logic [DATA_W-1:0] valA;
        logic [DATA_W-1:0] valB;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
        logic [3:0]        srcA;
        logic [3:0]        srcB;
        logic              is_bubble;
    } stage_t;

    // nop with no register traffic, status AOK
    localparam stage_t BUBBLE = '{
        stat: 4'b1000, icode: 4'h1, ifun: 4'h0,
        valC: '0, valA: '0, valB: '0,
        dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF,
        is_bubble: 1'b1
    };

    localparam logic [7:0] MAX_RUN = 8'(MAX_STALL);

    stage_t     stage_q, stage_d;
    logic [7:0] run_q, run_d;
    logic       err_q, err_d;
    logic       tmo_q, tmo_d;

    // Next-state selection: stall holds, else bubble, else load decode outputs.
    always_comb begin
        stage_d = stage_q;
        run_d   = 8'd0;
        err_d   = err_q | (E_stall & E_bubble);
        tmo_d   = tmo_q;
        if (E_stall) begin
            run_d = (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
            // Saturation at 255 means a run can never step past MAX_STALL=255.
            if (run_q == MAX_RUN && run_q != 8'hFF) begin
                tmo_d = 1'b1;
            end
        end else if (E_bubble) begin
            stage_d = BUBBLE;
        end else begin
            stage_d = '{
                stat: d_stat, icode: d_icode, ifun: d_ifun,
                valC: d_valC, valA: d_valA, valB: d_valB,
                dstE: d_dstE, dstM: d_dstM, srcA: d_srcA, srcB: d_srcB,
                is_bubble: 1'b0
            };
        end
    end

    // Stage contents and watchdog state; reset loads the bubble immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
            run_q   <= 8'd0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            run_q   <= run_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign E_stat        = stage_q.stat;
    assign E_icode       = stage_q.icode;
    assign E_ifun        = stage_q.ifun;
    assign E_valC        = stage_q.valC;
    assign E_valA        = stage_q.valA;
    assign E_valB        = stage_q.valB;
    assign E_dstE        = stage_q.dstE;
    assign E_dstM        = stage_q.dstM;
    assign E_srcA        = stage_q.srcA;
    assign E_srcB        = stage_q.srcB;
    assign E_is_bubble   = stage_q.is_bubble;
    assign ctrl_err      = err_q;
    assign stall_timeout = tmo_q;
    assign stall_run     = run_q;

`ifdef PIPE_E_PERF_CNT_EN
    logic [31:0] pstall_q, pbub_q, pinstr_q;

    // Event counters, free-running and wrapping; classification mirrors the stage priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstall_q <= 32'd0;
            pbub_q   <= 32'd0;
            pinstr_q <= 32'd0;
        end else if (E_stall) begin
            pstall_q <= pstall_q + 32'd1;
        end else if (E_bubble) begin
            pbub_q   <= pbub_q + 32'd1;
        end else if (d_icode != 4'h1) begin
            pinstr_q <= pinstr_q + 32'd1;
        end
    end

    assign perf_stall_cnt  = pstall_q;
    assign perf_bubble_cnt = pbub_q;
    assign perf_instr_cnt  = pinstr_q;
`endif

endmodule
